// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: shares one downstream cbus port between NUM_MASTERS
// upstream masters. A grant is held for a whole burst and released on the
// beat that carries ready=1 and last=1. Masters are picked round-robin,
// starting after the most recently completed master.

package cbus_pkg;

    // Burst length encoding carried in the request.
    typedef enum logic [2:0] {
        MLEN1 = 3'd0,
        MLEN2 = 3'd1,
        MLEN4 = 3'd2,
        MLEN8 = 3'd3
    } mlen_t;

    // Upstream/downstream request: 151 bits.
    typedef struct packed {
        logic        valid;
        logic        wr;
        logic [3:0]  id;
        logic [1:0]  burst;
        logic        cached;
        mlen_t       len;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } cbus_req_t;

    // Response beat: 66 bits.
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] rdata;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_MASTERS],
    output cbus_resp_t       iresps [NUM_MASTERS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Index of the last master; the reset value of the "last completed"
    // pointer so that master 0 is first in line after reset.
    localparam logic [IDX_W-1:0] LAST_MASTER = IDX_W'(NUM_MASTERS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last_idx;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_last_idx_nxt;

    logic             w_found;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_cand;
    logic             w_hit;
    logic             w_burst_done;

    // The final beat of a burst is the one the bridge accepts with last set.
    assign w_burst_done = oresp.ready & oresp.last;

    // Round-robin scan starting one past the last completed master.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_hit    = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_cand   = IDX_W'((int'(r_last_idx) + 1 + k) % NUM_MASTERS);
            w_hit    = ~w_found & ireqs[w_cand].valid;
            w_winner = w_hit ? w_cand : w_winner;
            w_found  = w_found | ireqs[w_cand].valid;
        end
    end

    // Next-state logic: IDLE arbitrates for one cycle, GRANT holds until the
    // last beat. GRANT always returns through IDLE, never straight to GRANT.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_last_idx_nxt = r_last_idx;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_idx_nxt   = w_winner;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_burst_done) begin
                    w_state_nxt    = S_IDLE;
                    w_last_idx_nxt = r_idx;
                end else begin
                    // A master dropping valid mid-burst does not end the grant.
                    w_state_nxt = S_GRANT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and grant registers; reset clears any grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_last_idx <= LAST_MASTER;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
        end
    end

    // Steering: the granted master is wired straight through in both
    // directions. oreq depends only on registered state and ireqs, never on
    // oresp, so no combinational loop can form through the bridge.
    always_comb begin
        oreq      = '0;
        busy      = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            iresps[j] = '0;
        end
        if (r_state == S_GRANT) begin
            oreq      = ireqs[r_idx];
            busy      = 1'b1;
            grant_idx = r_idx;
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (IDX_W'(j) == r_idx) begin
                    iresps[j] = oresp;
                end else begin
                    iresps[j] = '0;
                end
            end
        end else begin
            oreq      = '0;
            busy      = 1'b0;
            grant_idx = '0;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: the bridge-side stimulus pushes the
// expected beat (granted master, forwarded request, returned response) into a
// queue; a negedge monitor pops and compares on every accepted beat.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N  = 2;
    localparam int IW = 1;

    logic          clk = 1'b0;
    logic          reset;
    cbus_req_t     ireqs  [N];
    cbus_resp_t    iresps [N];
    cbus_req_t     oreq;
    cbus_resp_t    oresp;
    logic          busy;
    logic [IW-1:0] grant_idx;

    typedef struct packed {
        logic [IW-1:0] idx;
        cbus_req_t     req;
        cbus_resp_t    resp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    cbus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    function automatic cbus_req_t mk_req(input logic wr, input logic [63:0] addr, input mlen_t len, input logic [3:0] id);
        cbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.wr     = wr;
        r.id     = id;
        r.burst  = 2'b01;
        r.cached = 1'b1;
        r.len    = len;
        r.size   = 3'd3;
        r.addr   = addr;
        r.wdata  = {28'hA5A5000, id, addr[31:0]};
        r.wstrb  = wr ? 8'hFF : 8'h00;
        return r;
    endfunction

    // Monitor: every beat the bridge accepts must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && busy && oresp.ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_beat: actual grant_idx %0d required no beat", grant_idx);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_grant_idx", 256'(grant_idx), 256'(mon_e.idx));
                chk("beat_oreq", 256'(oreq), 256'(mon_e.req));
                for (int j = 0; j < N; j++) begin
                    if (j == int'(mon_e.idx)) chk("beat_iresp_granted", 256'(iresps[j]), 256'(mon_e.resp));
                    else                      chk("beat_iresp_other", 256'(iresps[j]), 256'(0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 256'(busy), 256'(1'b0));
        chk({tag, "_oreq"}, 256'(oreq), 256'(0));
        chk({tag, "_grant_idx"}, 256'(grant_idx), 256'(0));
        for (int j = 0; j < N; j++) chk({tag, "_iresp"}, 256'(iresps[j]), 256'(0));
    endtask

    // Bridge model: wait for a grant, then return nbeats beats for master m,
    // optionally stalling stall_len cycles before beat stall_at.
    task automatic serve(input int m, input cbus_req_t req, input int nbeats,
                         input int exp_wait, input int stall_at, input int stall_len);
        int         waited;
        cbus_resp_t r;
        exp_t       e;
        waited = 0;
        while (!oreq.valid && waited < 20) begin
            tick();
            waited++;
        end
        if (!oreq.valid) begin
            n_vec++;
            n_fail++;
            $display("FAIL grant_timeout: actual no grant after %0d cycles required master %0d", waited, m);
            return;
        end
        if (exp_wait >= 0) chk("grant_latency", 256'(waited), 256'(exp_wait));
        for (int b = 0; b < nbeats; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    oresp = '0;
                    tick();
                    chk("stall_hold", 256'({busy, grant_idx}), 256'({1'b1, IW'(m)}));
                end
            end
            r       = '0;
            r.ready = 1'b1;
            r.last  = (b == nbeats - 1);
            r.rdata = {16'(16'hD000 + b), 16'(m), 32'(32'h1234_5678 + b)};
            oresp   = r;
            e.idx   = IW'(m);
            e.req   = req;
            e.resp  = r;
            exp_q.push_back(e);
            tick();
        end
        oresp = '0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        cbus_req_t  r1w, r0a, r1a, ra, rb, r8, r4, r0b;
        cbus_resp_t rr;
        int         waited;

        reset = 1'b1;
        oresp = '0;
        for (int j = 0; j < N; j++) ireqs[j] = '0;

        // Reset, then ten idle cycles.
        repeat (3) tick();
        check_idle("in_reset");
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle("idle");
        end

        // Single master 1 write burst of 4 beats.
        r1w = mk_req(1'b1, 64'h0000_0000_8000_1000, MLEN4, 4'h1);
        ireqs[1] = r1w;
        serve(1, r1w, 4, 1, -1, 0);
        chk("busy_after_last", 256'(busy), 256'(1'b0));
        ireqs[1] = '0;
        tick();
        check_idle("after_single");

        // Simultaneous requests right after reset: master 0 first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r0a = mk_req(1'b0, 64'h0000_0000_0000_2000, MLEN1, 4'h2);
        r1a = mk_req(1'b0, 64'h0000_0000_8000_3000, MLEN1, 4'h3);
        ireqs[0] = r0a;
        ireqs[1] = r1a;
        serve(0, r0a, 1, 1, -1, 0);
        ireqs[0] = '0;
        serve(1, r1a, 1, 1, -1, 0);
        ireqs[1] = '0;

        // Both masters always requesting: grants alternate, one idle cycle apart.
        ra = mk_req(1'b0, 64'h0000_0000_0000_4000, MLEN2, 4'h4);
        rb = mk_req(1'b1, 64'h0000_0000_8000_5000, MLEN2, 4'h5);
        ireqs[0] = ra;
        ireqs[1] = rb;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) serve(0, ra, 2, 1, -1, 0);
            else            serve(1, rb, 2, 1, -1, 0);
        end

        // Long burst with a mid-burst stall: master 1 waits for the real last.
        r8 = mk_req(1'b0, 64'h0000_0000_0000_6000, MLEN8, 4'h6);
        ireqs[0] = r8;
        serve(0, r8, 8, 1, 4, 3);
        serve(1, rb, 2, 1, -1, 0);
        ireqs[0] = '0;
        ireqs[1] = '0;
        tick();

        // Ready without last while idle is ignored.
        rr       = '0;
        rr.ready = 1'b1;
        rr.rdata = 64'hFFFF_0000_FFFF_0000;
        oresp    = rr;
        repeat (3) tick();
        check_idle("idle_ready");
        oresp = '0;

        // Reset during beat 2 of a master 1 burst.
        r4 = mk_req(1'b1, 64'h0000_0000_8000_7000, MLEN4, 4'h7);
        ireqs[1] = r4;
        waited = 0;
        while (!busy && waited < 20) begin
            tick();
            waited++;
        end
        chk("midreset_grant", 256'({busy, grant_idx}), 256'({1'b1, 1'b1}));
        if (busy) begin
            rr       = '0;
            rr.ready = 1'b1;
            rr.rdata = 64'h0BEA_7001_0000_0001;
            oresp    = rr;
            exp_q.push_back('{idx: 1'b1, req: r4, resp: rr});
            tick();
        end
        rr.rdata = 64'h0BEA_7002_0000_0002;
        oresp    = rr;
        #2;
        reset = 1'b1;
        #1;
        check_idle("midreset");
        oresp = '0;
        tick();
        r0b = mk_req(1'b0, 64'h0000_0000_0000_8000, MLEN1, 4'h8);
        ireqs[0] = r0b;
        reset = 1'b0;
        serve(0, r0b, 1, 1, -1, 0);
        ireqs[0] = '0;
        ireqs[1] = '0;

        repeat (3) tick();
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one downstream cache-bus port (cbus_req_t/cbus_resp_t) between NUM_MASTERS upstream masters, e.g. master 0 = icache refill, master 1 = dcache refill/writeback.
- Sits between the caches and the AXI bridge.
- Grants one master at a time and holds the grant for the whole burst, until the beat with ready=1 and last=1.
- Chooses the next master round-robin.

Parameters:
- NUM_MASTERS, 2, number of upstream cbus masters (2..8).
- IDX_W, $clog2(NUM_MASTERS) (min 1), width of the grant index; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ireqs  in  NUM_MASTERS x cbus_req_t (151 b each)  upstream requests.
- iresps  out  NUM_MASTERS x cbus_resp_t (66 b each)  upstream responses.
- oreq  out  cbus_req_t  downstream request.
- oresp  in  cbus_resp_t  downstream response.
- busy  out  1  high while a grant is active.
- grant_idx  out  IDX_W  index of the granted master; valid only while busy=1.

Behaviour:
- States:
  - IDLE: no grant.
  - GRANT: one master is connected to the downstream port.
- Registers:
  - state
  - idx (IDX_W): granted master.
  - last_idx (IDX_W): most recently completed master.
- Reset (asynchronous, takes effect immediately): state=IDLE, idx=0, last_idx=NUM_MASTERS-1, so master 0 has first priority.
- Reset values of outputs: oreq='0, all iresps='0, busy=0, grant_idx=0.
- IDLE:
  - oreq='0 and all iresps='0.
  - Scan ireqs[(last_idx+1+k) mod NUM_MASTERS].valid for k=0..NUM_MASTERS-1; the first set one wins.
  - If a winner exists: idx<=winner and state<=GRANT on the next edge. Otherwise stay in IDLE.
  - Arbitration cost: 1 cycle. A request first reaches oreq on the cycle after it is seen in IDLE.
- GRANT:
  - oreq = ireqs[idx], passed through combinationally with all fields, including valid.
  - iresps[idx] = oresp, combinationally; every other iresps[j]='0.
  - busy=1, grant_idx=idx.
  - Exit: when oresp.ready && oresp.last, state<=IDLE and last_idx<=idx on that edge.
  - No other condition ends the grant. If the granted master drops valid mid-burst, that is a protocol violation; the arbiter still holds the grant and forwards valid=0.
- Back-to-back bursts: after a burst completes there is one IDLE cycle with oreq.valid=0 before the next grant. There is no direct GRANT->GRANT transition.
- Fairness:
  - With all masters continuously requesting, grants rotate 0,1,...,N-1,0,...
  - Any requesting master is granted within NUM_MASTERS bursts.
- Non-granted masters see ready=0 and hold their request. They are never dropped.
- oresp.ready with last=0 in IDLE: ignored, no state change.
- oresp.ready && last in the first GRANT cycle: legal; the grant ends on that edge (single-beat transfer).
- Reset asserted mid-burst: returns to IDLE immediately and oreq.valid goes 0 combinationally. The downstream bridge must also be reset by the same signal.
- No combinational path from oresp to oreq. iresps depends combinationally only on oresp and registered idx/state.

Test Plan:
- Reset then idle: ireqs all valid=0 for 10 cycles -> oreq.valid=0, busy=0, iresps all 0.
- Single master: ireqs[1] write, addr=0x80001000, len=MLEN4; bridge returns ready on 4 beats, last on beat 4 -> oreq mirrors ireqs[1] from cycle 1 after request; iresps[1] carries the 4 beats; iresps[0]=0; busy falls the cycle after last; grant_idx=1 throughout.
- Simultaneous requests after reset: both masters valid at cycle 0, MLEN1 reads -> master 0 granted first; master 1 granted in the cycle after master 0's last+1 idle cycle; master 1 saw ready=0 meanwhile.
- Round-robin fairness: both masters permanently valid, 6 bursts of MLEN2 -> grant order 0,1,0,1,0,1; exactly one idle cycle between bursts.
- Ready without last: during a GRANT on master 0 with MLEN8, ready pulses with last=0 for 7 beats and stalls 3 cycles mid-burst -> grant held, no switch to master 1 until the 8th beat with last=1.
- Reset mid-burst: assert reset during beat 2 of a MLEN4 burst by master 1 -> oreq.valid=0 immediately, busy=0, grant_idx=0; after release with both valid, master 0 is granted first.
